// File: rtl/alif_param_serializer_if.sv
// -----------------------------------------------------------------------------
// alif_param_serializer_if
//   Bundles the host-side request signals and the neuron-side serial pins of
//   the ALIF parameter serializer.
//
//   Signals
//     start            host -> ser   request to send one frame
//     params           host -> ser   parallel parameter set, word k at
//                                    params[k*PARAM_W +: PARAM_W]
//     params_ready_in  neuron -> ser acknowledgement (neuron params_ready)
//     load_mode        ser -> neuron serial load enable
//     serial_data      ser -> neuron serial data bit
//     busy             ser -> host   serializer not idle
//     done             ser -> host   one-cycle end-of-frame pulse
//     timeout_err      ser -> host   sticky "no acknowledgement" flag
//
//   Modports
//     slave  : the serializer itself
//     master : the host / harness driving it
// -----------------------------------------------------------------------------
interface alif_param_serializer_if #(
    parameter int NUM_PARAMS = 4,
    parameter int PARAM_W    = 8
);
    logic                          start;
    logic [NUM_PARAMS*PARAM_W-1:0] params;
    logic                          params_ready_in;
    logic                          load_mode;
    logic                          serial_data;
    logic                          busy;
    logic                          done;
    logic                          timeout_err;

    modport slave (
        input  start, params, params_ready_in,
        output load_mode, serial_data, busy, done, timeout_err
    );

    modport master (
        output start, params, params_ready_in,
        input  load_mode, serial_data, busy, done, timeout_err
    );
endinterface

// File: rtl/alif_param_serializer.sv
// -----------------------------------------------------------------------------
// alif_param_serializer
//   Configuration-side partner of the ALIF neuron serial parameter loader.
//   A parallel parameter set is captured on start, then shifted out one bit
//   per clock on serial_data while load_mode is high (word 0 first, each word
//   MSB first). Afterwards the block waits up to TIMEOUT cycles for the
//   neuron's params_ready acknowledgement and ends the frame with a one-cycle
//   done pulse; a missing acknowledgement raises the sticky timeout_err.
//
//   Ports
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    alif_param_serializer_if.slave (start, params, params_ready_in,
//            load_mode, serial_data, busy, done, timeout_err)
//
//   Build option
//     ALIF_SER_PARITY_EN : when defined, an even-parity bit (XOR of the word)
//                          follows every PARAM_W-bit word inside the frame.
// -----------------------------------------------------------------------------
module alif_param_serializer #(
    parameter int NUM_PARAMS = 4,
    parameter int PARAM_W    = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    alif_param_serializer_if.slave        bus
);

`ifdef ALIF_SER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int SLOT_W     = PARAM_W + PAR_BITS;
    localparam int FRAME_BITS = NUM_PARAMS * SLOT_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int WAIT_W     = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  BIT_LAST_IDX = CNT_W'(FRAME_BITS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] frame;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  load_mode_q, load_mode_d;
    logic                  serial_data_q, serial_data_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  busy, done;

    // Lay out the frame so its MSB is the first bit on the wire: word 0 in
    // the top slot, each slot holding the word MSB first (then parity).
    always_comb begin
        frame = '0;
        for (int k = 0; k < NUM_PARAMS; k++) begin
`ifdef ALIF_SER_PARITY_EN
            frame[FRAME_BITS-1-k*SLOT_W -: SLOT_W] =
                {bus.params[k*PARAM_W +: PARAM_W], ^bus.params[k*PARAM_W +: PARAM_W]};
`else
            frame[FRAME_BITS-1-k*SLOT_W -: SLOT_W] = bus.params[k*PARAM_W +: PARAM_W];
`endif
        end
    end

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            load_mode_q   <= 1'b0;
            serial_data_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            load_mode_q   <= load_mode_d;
            serial_data_q <= serial_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_SHIFT;
            S_SHIFT: if (bit_cnt_q == '0) state_d = S_WAIT;
            // Acknowledge is checked before the timeout so a ready arriving on
            // the final wait cycle still counts as success.
            S_WAIT:  if (bus.params_ready_in || wait_cnt_q == WAIT_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------- outputs / datapath
    // load_mode/serial_data are computed one cycle ahead and registered, so the
    // neuron pins never see a combinational path from the host inputs.
    always_comb begin
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        load_mode_d   = 1'b0;
        serial_data_d = 1'b0;
        timeout_err_d = timeout_err_q;
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // First bit goes out on the accepting edge; the register
                    // keeps the remainder, already shifted.
                    load_mode_d   = 1'b1;
                    serial_data_d = frame[FRAME_BITS-1];
                    shreg_d       = frame << 1;
                    bit_cnt_d     = BIT_LAST_IDX;
                    wait_cnt_d    = '0;
                    timeout_err_d = 1'b0;
                end
            end
            S_SHIFT: begin
                // bit_cnt_q counts bits still to be placed after the one now
                // on the pins; zero means the current bit is the last.
                if (bit_cnt_q != '0) begin
                    load_mode_d   = 1'b1;
                    serial_data_d = shreg_q[FRAME_BITS-1];
                    shreg_d       = shreg_q << 1;
                    bit_cnt_d     = bit_cnt_q - 1'b1;
                end else begin
                    wait_cnt_d    = '0;
                end
            end
            S_WAIT: begin
                if (!bus.params_ready_in) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WAIT_LAST) timeout_err_d = 1'b1;
                end
            end
            S_DONE: begin
                wait_cnt_d = '0;
            end
            default: ;
        endcase
    end

    assign bus.load_mode   = load_mode_q;
    assign bus.serial_data = serial_data_q;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.timeout_err = timeout_err_q;

endmodule
